// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the fetch stage.
//
// Holds the architectural PC and picks the next fetch address from, in
// priority order: exception vector, exception return (EPC), branch target,
// jump target, hold (stall) or sequential increment. It also keeps the
// exception PC (EPC) and exception-level (EXL) flag, and turns a misaligned
// branch/jump target into an exception that records the current PC.
//
// Parameters:
//   ADDR_W    PC/EPC width in bits
//   RESET_VEC PC value while reset is asserted (truncated to ADDR_W)
//   EXC_VEC   exception handler address (truncated to ADDR_W)
//   INC       sequential increment in bytes (power of two, >= 1)
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-high reset
//   i_stall      hold PC (fetch back-pressure)
//   i_branch     take branch this cycle, target i_branch_pc
//   i_jump       take jump this cycle, target i_jump_pc
//   i_exc        exception request, i_exc_pc is the faulting PC
//   i_eret       return from exception
//   o_pc         current fetch address (registered)
//   o_epc        saved exception PC (registered)
//   o_exl        exception level flag (registered)
//   o_redirect   pulse: o_pc was loaded non-sequentially
//   o_addr_err   pulse: a misaligned redirect became an exception
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
  parameter int          INC       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_branch_pc,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_pc,
  input  logic              i_exc,
  input  logic [ADDR_W-1:0] i_exc_pc,
  input  logic              i_eret,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_epc,
  output logic              o_exl,
  output logic              o_redirect,
  output logic              o_addr_err
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
  // Low bits that must be zero in a redirect target; all-zero when INC=1,
  // so nothing is ever misaligned in that configuration.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

  // True when the target has any of the alignment bits set.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] target);
    return |(target & ALIGN_MASK);
  endfunction

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              exl_q, exl_d;
  logic              redirect_q, redirect_d;
  logic              addr_err_q, addr_err_d;

  logic              redir_take_s;
  logic [ADDR_W-1:0] redir_pc_s;

  // Winning redirect source: branch beats jump.
  always_comb begin
    redir_take_s = i_branch | i_jump;
    if (i_branch) begin
      redir_pc_s = i_branch_pc;
    end else begin
      redir_pc_s = i_jump_pc;
    end
  end

  // Next-state selection in priority order.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    exl_d      = exl_q;
    redirect_d = 1'b0;
    addr_err_d = 1'b0;
    if (i_exc) begin
      pc_d       = EXC_PC;
      redirect_d = 1'b1;
      // Nested exceptions keep the original EPC.
      if (!exl_q) begin
        epc_d = i_exc_pc;
        exl_d = 1'b1;
      end else begin
        epc_d = epc_q;
        exl_d = exl_q;
      end
    end else if (i_eret) begin
      pc_d       = epc_q;
      exl_d      = 1'b0;
      redirect_d = 1'b1;
    end else if (redir_take_s) begin
      redirect_d = 1'b1;
      if (is_misaligned(redir_pc_s)) begin
        // Address error: the instruction at the current PC is the culprit.
        pc_d       = EXC_PC;
        addr_err_d = 1'b1;
        if (!exl_q) begin
          epc_d = pc_q;
          exl_d = 1'b1;
        end else begin
          epc_d = epc_q;
          exl_d = exl_q;
        end
      end else begin
        pc_d = redir_pc_s;
      end
    end else if (i_stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + INC_V;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      exl_q      <= 1'b0;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      exl_q      <= exl_d;
      redirect_q <= redirect_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_epc      = epc_q;
  assign o_exl      = exl_q;
  assign o_redirect = redirect_q;
  assign o_addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- directed self-checking bench for pc_gen with default
// parameters (ADDR_W=32, RESET_VEC=0, EXC_VEC=0x180, INC=4).
module tb_pc_gen;

  logic        i_clk;
  logic        i_rst;
  logic        i_stall;
  logic        i_branch;
  logic [31:0] i_branch_pc;
  logic        i_jump;
  logic [31:0] i_jump_pc;
  logic        i_exc;
  logic [31:0] i_exc_pc;
  logic        i_eret;
  logic [31:0] o_pc;
  logic [31:0] o_epc;
  logic        o_exl;
  logic        o_redirect;
  logic        o_addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stall     (i_stall),
    .i_branch    (i_branch),
    .i_branch_pc (i_branch_pc),
    .i_jump      (i_jump),
    .i_jump_pc   (i_jump_pc),
    .i_exc       (i_exc),
    .i_exc_pc    (i_exc_pc),
    .i_eret      (i_eret),
    .o_pc        (o_pc),
    .o_epc       (o_epc),
    .o_exl       (o_exl),
    .o_redirect  (o_redirect),
    .o_addr_err  (o_addr_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_ctrl();
    i_stall  = 1'b0;
    i_branch = 1'b0;
    i_jump   = 1'b0;
    i_exc    = 1'b0;
    i_eret   = 1'b0;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_branch_pc = 32'h0;
    i_jump_pc   = 32'h0;
    i_exc_pc    = 32'h0;
    clear_ctrl();

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pc", o_pc, 32'h0);
      check("rst_redir", 32'(o_redirect), 32'h0);
    end
    check("rst_epc", o_epc, 32'h0);
    check("rst_exl", 32'(o_exl), 32'h0);
    check("rst_aerr", 32'(o_addr_err), 32'h0);

    // Sequential increment
    i_rst = 1'b0;
    step(); check("inc_4", o_pc, 32'h4);  check("inc_redir", 32'(o_redirect), 32'h0);
    step(); check("inc_8", o_pc, 32'h8);
    step(); check("inc_c", o_pc, 32'hC);
    step(); check("inc_10", o_pc, 32'h10);

    // Stall holds
    i_stall = 1'b1;
    step(); check("stall1", o_pc, 32'h10);
    step(); check("stall2", o_pc, 32'h10);  check("stall_redir", 32'(o_redirect), 32'h0);
    // Branch overrides stall
    i_branch = 1'b1; i_branch_pc = 32'h200;
    step(); check("stbr_pc", o_pc, 32'h200); check("stbr_redir", 32'(o_redirect), 32'h1);
    clear_ctrl();
    step(); check("post_br_pc", o_pc, 32'h204); check("post_br_redir", 32'(o_redirect), 32'h0);

    // Exception, nested exception, eret
    i_exc = 1'b1; i_exc_pc = 32'h40;
    step();
    check("exc_pc", o_pc, 32'h180); check("exc_epc", o_epc, 32'h40);
    check("exc_exl", 32'(o_exl), 32'h1); check("exc_redir", 32'(o_redirect), 32'h1);
    i_exc_pc = 32'h184;
    step();
    check("nest_pc", o_pc, 32'h180); check("nest_epc", o_epc, 32'h40);
    check("nest_exl", 32'(o_exl), 32'h1);
    clear_ctrl(); i_eret = 1'b1;
    step();
    check("eret_pc", o_pc, 32'h40); check("eret_exl", 32'(o_exl), 32'h0);
    check("eret_redir", 32'(o_redirect), 32'h1);
    clear_ctrl();
    step(); check("post_eret_pc", o_pc, 32'h44);

    // Misaligned jump from 0x30
    i_branch = 1'b1; i_branch_pc = 32'h30;
    step(); check("br30", o_pc, 32'h30);
    clear_ctrl(); i_jump = 1'b1; i_jump_pc = 32'h102;
    step();
    check("mj_pc", o_pc, 32'h180); check("mj_aerr", 32'(o_addr_err), 32'h1);
    check("mj_epc", o_epc, 32'h30); check("mj_exl", 32'(o_exl), 32'h1);
    check("mj_redir", 32'(o_redirect), 32'h1);
    clear_ctrl();
    step();
    check("mj_next_pc", o_pc, 32'h184); check("mj_aerr_clr", 32'(o_addr_err), 32'h0);
    check("mj_redir_clr", 32'(o_redirect), 32'h0);
    i_eret = 1'b1;
    step(); check("mj_eret_pc", o_pc, 32'h30); check("mj_eret_exl", 32'(o_exl), 32'h0);

    // All controls together: exception wins
    i_exc = 1'b1; i_exc_pc = 32'h88; i_eret = 1'b1;
    i_branch = 1'b1; i_branch_pc = 32'h300; i_jump = 1'b1; i_jump_pc = 32'h400;
    step();
    check("all_pc", o_pc, 32'h180); check("all_epc", o_epc, 32'h88);
    check("all_exl", 32'(o_exl), 32'h1);
    clear_ctrl(); i_eret = 1'b1;
    step(); check("all_eret_pc", o_pc, 32'h88); check("all_eret_exl", 32'(o_exl), 32'h0);

    // Branch beats jump; back-to-back redirects
    clear_ctrl(); i_branch = 1'b1; i_branch_pc = 32'h500; i_jump = 1'b1; i_jump_pc = 32'h600;
    step(); check("bj_pc", o_pc, 32'h500); check("bj_redir", 32'(o_redirect), 32'h1);
    clear_ctrl(); i_jump = 1'b1; i_jump_pc = 32'h700;
    step(); check("jmp_pc", o_pc, 32'h700); check("jmp_redir", 32'(o_redirect), 32'h1);
    // Misaligned branch wins over an aligned jump
    clear_ctrl(); i_branch = 1'b1; i_branch_pc = 32'h501; i_jump = 1'b1; i_jump_pc = 32'h600;
    step();
    check("mb_pc", o_pc, 32'h180); check("mb_epc", o_epc, 32'h700);
    check("mb_aerr", 32'(o_addr_err), 32'h1);
    clear_ctrl(); i_eret = 1'b1;
    step(); check("mb_eret_pc", o_pc, 32'h700);

    // Wrap at top of address space
    clear_ctrl(); i_branch = 1'b1; i_branch_pc = 32'hFFFF_FFFC;
    step(); check("wrap_top", o_pc, 32'hFFFF_FFFC);
    clear_ctrl();
    step(); check("wrap_zero", o_pc, 32'h0000_0000); check("wrap_redir", 32'(o_redirect), 32'h0);
    step(); check("wrap_four", o_pc, 32'h0000_0004);

    // Async reset mid-run with EXL set and PC at 0x80
    i_exc = 1'b1; i_exc_pc = 32'h99C;
    step(); check("pre_rst_epc", o_epc, 32'h99C);
    clear_ctrl(); i_branch = 1'b1; i_branch_pc = 32'h80;
    step(); check("pre_rst_pc", o_pc, 32'h80); check("pre_rst_exl", 32'(o_exl), 32'h1);
    clear_ctrl();
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_pc", o_pc, 32'h0); check("arst_exl", 32'(o_exl), 32'h0);
    check("arst_epc", o_epc, 32'h0); check("arst_redir", 32'(o_redirect), 32'h0);
    #2;
    i_rst = 1'b0;
    step(); check("post_arst_pc", o_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the ARC MIPS fetch stage. It holds the architectural PC and selects the next fetch address from five sources: sequential increment, branch, jump, exception vector and exception return. It also keeps an exception PC (EPC) and an exception-level (EXL) flag, and detects misaligned redirect targets. It sits between the decode/execute redirect logic and the instruction memory address port.

## Interface
- ADDR_W, 32, PC/EPC width in bits
- RESET_VEC, 32'h0000_0000, PC value while reset is asserted (truncated to ADDR_W)
- EXC_VEC, 32'h0000_0180, exception handler address (truncated to ADDR_W)
- INC, 4, sequential increment in bytes; power of two ≥1; ALIGN = $clog2(INC) low bits must be zero in aligned targets
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_stall  in  1  hold PC (fetch back-pressure)
- i_branch  in  1  take branch this cycle
- i_branch_pc  in  ADDR_W  branch target
- i_jump  in  1  take jump (j/jal/jr) this cycle
- i_jump_pc  in  ADDR_W  jump target
- i_exc  in  1  exception request; i_exc_pc is the faulting instruction PC
- i_exc_pc  in  ADDR_W  PC to save into EPC
- i_eret  in  1  return from exception
- o_pc  out  ADDR_W  current fetch address (registered)
- o_epc  out  ADDR_W  saved exception PC (registered)
- o_exl  out  1  exception level flag (registered)
- o_redirect  out  1  registered pulse: o_pc was loaded non-sequentially this cycle
- o_addr_err  out  1  registered pulse: a misaligned redirect was converted into an exception

## Operation
- Reset (i_rst high, asynchronous): o_pc=RESET_VEC, o_epc=0, o_exl=0, o_redirect=0, o_addr_err=0. Held while i_rst is high. First increment is on the first rising edge after deassertion.
- Misalignment check: a redirect is misaligned when any of target[ALIGN-1:0] is nonzero. It applies only to the winning redirect source (branch or jump). With INC=1 nothing is misaligned.
- Next-PC priority, highest first, evaluated every cycle:
  1. i_exc: o_pc<=EXC_VEC. If o_exl=0: o_epc<=i_exc_pc and o_exl<=1. If o_exl=1 (nested): o_epc and o_exl are unchanged. o_redirect<=1.
  2. i_eret: o_pc<=o_epc, o_exl<=0, o_redirect<=1. If o_exl=0, eret still loads o_epc and o_exl stays 0.
  3. i_branch: o_pc<=i_branch_pc, o_redirect<=1. i_jump is ignored when i_branch is also high.
  4. i_jump: o_pc<=i_jump_pc, o_redirect<=1.
  5. i_stall: o_pc holds, o_redirect<=0.
  6. Otherwise: o_pc<=o_pc+INC, modulo 2^ADDR_W (wraps to 0), o_redirect<=0.
- Misaligned winning redirect at level 3 or 4: treated as an exception with the current o_pc as the faulting PC.
  - o_pc<=EXC_VEC, o_addr_err<=1, o_redirect<=1.
  - If o_exl=0: o_epc<=o_pc and o_exl<=1. Otherwise EPC and EXL are unchanged.
- Redirects and exceptions override i_stall. A stall never blocks a control-flow change.
- o_addr_err and o_redirect are single-cycle pulses, cleared in any cycle without the triggering condition.
- Arithmetic is unsigned ADDR_W bits. Carry out is discarded. No sign extension happens inside the block; targets arrive fully formed.

## Timing
- All outputs are registered. Inputs sampled at edge N are reflected on o_pc/o_epc/o_exl/o_redirect/o_addr_err after edge N (1-cycle latency).
- No combinational path from any input to any output.
- i_rst asserted mid-operation clears all state immediately, without waiting for a clock edge. Pending redirects are lost.
- Back-to-back redirects on consecutive cycles are each taken. o_redirect stays high for each such cycle.
- i_exc and i_eret in the same cycle: the exception wins and eret is dropped.

## Test plan
- Reset/increment: hold i_rst 3 cycles then release with no controls → o_pc=0 during reset, then 4, 8, 12; o_redirect=0 throughout.
- Stall vs branch: at o_pc=0x10, assert i_stall 2 cycles → o_pc stays 0x10. Then assert i_stall and i_branch with i_branch_pc=0x200 together → o_pc=0x200, o_redirect=1 for one cycle.
- Exception/eret with nesting, o_exl=0 at start:
  - i_exc with i_exc_pc=0x40 → o_pc=0x180, o_epc=0x40, o_exl=1.
  - Second i_exc with i_exc_pc=0x184 → o_pc=0x180, o_epc=0x40.
  - i_eret → o_pc=0x40, o_exl=0.
- Misaligned jump: at o_pc=0x30, i_jump with i_jump_pc=0x102 → o_pc=0x180, o_addr_err=1 for one cycle, o_epc=0x30, o_exl=1.
- Priority and wrap:
  - i_exc, i_eret, i_branch and i_jump all asserted together → exception path taken.
  - Separately, branch to 0xFFFF_FFFC, then let the PC run free → o_pc=0xFFFF_FFFC, then 0x0000_0000.
- Async reset mid-run: at o_pc=0x80, assert i_rst between clock edges → o_pc=0, o_exl=0, o_epc=0 before the next rising edge.
